// File: rtl/di_initiator.sv
// di_initiator: burst master for the device-interface register bus (diRead/diWrite strobes paced by rdwr_ready).
// Define DI_INITIATOR_TIMEOUT_EN to abort a burst after TIMEOUT_CYCLES consecutive not-ready XFER cycles.
module di_initiator #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_ep,
    input  logic [15:0] cmd_reg,
    input  logic [15:0] cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        error,
    output logic [15:0] diEpAddr,
    output logic [15:0] diRegAddr,
    output logic [15:0] diRegDataIn,
    output logic        diWrite,
    output logic        diRead,
    input  logic [15:0] diRegDataOut,
    input  logic        rdwr_ready
);

    if (SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("di_initiator: SETUP_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_XFER, S_GAP, S_RDLAT, S_DONE
    } state_e;

    localparam int SW = $clog2(SETUP_CYCLES + 1);

    state_e        state_q, state_d;
    logic [15:0]   ep_q, ep_d, reg_q, reg_d, rem_q, rem_d;
    logic [15:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic          write_q, write_d, rvalid_q, rvalid_d;
    logic [SW-1:0] setup_q, setup_d;
    logic          rd_strobe, wr_strobe;
`ifdef DI_INITIATOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 8;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          tmo_hit;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        ep_d      = ep_q;
        reg_d     = reg_q;
        rem_d     = rem_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        setup_d   = setup_q;
        rd_strobe = 1'b0;
        wr_strobe = 1'b0;
`ifdef DI_INITIATOR_TIMEOUT_EN
        tmo_d   = '0;
        err_d   = err_q;
        tmo_hit = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ep_d    = cmd_ep;
                    reg_d   = cmd_reg;
                    rem_d   = cmd_len;
                    write_d = cmd_write;
                    setup_d = '0;
`ifdef DI_INITIATOR_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = (cmd_len == 16'd0) ? S_DONE : S_SETUP;
                end
            end
            // Terminals derive rdwr_ready from the address, so it must settle before the first strobe.
            S_SETUP: begin
                if (setup_q == SW'(SETUP_CYCLES - 1)) begin
                    state_d = S_XFER;
                end else begin
                    setup_d = setup_q + 1'b1;
                end
            end
            S_XFER: begin
                if (write_q) begin
                    wr_strobe = rdwr_ready & wr_valid;
                end else begin
                    rd_strobe = rdwr_ready;
                end
`ifdef DI_INITIATOR_TIMEOUT_EN
                tmo_d = tmo_q;
                if (!rdwr_ready) begin
                    if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
                    tmo_hit = (tmo_q >= TW'(TIMEOUT_CYCLES - 1));
                end
`endif
                if (rd_strobe || wr_strobe) begin
                    if (rem_q != 16'd0) rem_d = rem_q - 16'd1;
                    if (wr_strobe) wdata_d = wr_data;
                    state_d = write_q ? S_GAP : S_RDLAT;
`ifdef DI_INITIATOR_TIMEOUT_EN
                    tmo_d = '0;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_DONE;
`endif
                end
            end
            S_RDLAT: begin
                rdata_d  = diRegDataOut;
                rvalid_d = 1'b1;
                state_d  = (rem_q == 16'd0) ? S_DONE : S_GAP;
            end
            // rdwr_ready may still reflect the previous strobe here, so it is ignored for one cycle.
            S_GAP:   state_d = (rem_q == 16'd0) ? S_DONE : S_XFER;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ep_q     <= '0;
            reg_q    <= '0;
            rem_q    <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            setup_q  <= '0;
`ifdef DI_INITIATOR_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ep_q     <= ep_d;
            reg_q    <= reg_d;
            rem_q    <= rem_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            setup_q  <= setup_d;
`ifdef DI_INITIATOR_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    // Strobes and pulses are masked while reset is held so an aborted burst issues nothing more.
    assign cmd_ready   = (state_q == S_IDLE);
    assign diRead      = rd_strobe & ~reset;
    assign diWrite     = wr_strobe & ~reset;
    assign wr_ready    = diWrite;
    assign diRegDataIn = diWrite ? wr_data : wdata_q;
    assign diEpAddr    = ep_q;
    assign diRegAddr   = reg_q;
    assign rd_valid    = rvalid_q;
    assign rd_data     = rdata_q;
    assign done        = (state_q == S_DONE) & ~reset;
`ifdef DI_INITIATOR_TIMEOUT_EN
    assign error       = done & err_q;
`else
    assign error       = 1'b0;
`endif

endmodule
